button_event_gen: RTL and testbench

- Sits directly downstream of the NES-pad input controller, which runs the latch/pulse sequence and delivers one 8-bit button snapshot per poll.
- Debounces the snapshots, detects new presses, and generates DAS/ARR auto-repeat for LEFT/RIGHT/DOWN.
- Serialises simultaneous events into a small FIFO of 3-bit move commands, consumed by the Tetris game-logic FSM over a valid/ready handshake.

---
 rtl/button_event_gen.sv | 156 +++++++++++++++
 tb/tb_button_event_gen.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/button_event_gen.sv
// button_event_gen: debounces NES-pad snapshots, detects presses, generates
// DAS/ARR auto-repeat for Left/Right/Down and queues 3-bit move commands.
// Ports: clk, reset (sync, active-low), buttons/buttons_valid (raw snapshot
// strobe), cmd/cmd_valid/cmd_ready (FWFT command FIFO head), held
// (debounced state), overflow (sticky lost-event flag).
module button_event_gen #(
  parameter int DEBOUNCE_POLLS = 2,
  parameter int DAS_POLLS      = 10,
  parameter int ARR_POLLS      = 3,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] buttons,
  input  logic       buttons_valid,
  output logic [2:0] cmd,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [7:0] held,
  output logic       overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int REP_W = 7;
  localparam logic [2:0]       DB_MAX  = 3'(DEBOUNCE_POLLS);
  localparam logic [REP_W-1:0] REP_DAS = REP_W'(DAS_POLLS);
  localparam logic [REP_W-1:0] REP_TOP = REP_W'(DAS_POLLS + ARR_POLLS);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [2:0]       db_cnt  [8];
  logic [2:0]       db_nxt  [8];
  logic [7:0]       held_nxt;
  logic [7:0]       rise;
  // Repeat slots: 0 Left, 1 Right, 2 Down (same as their command codes).
  logic [REP_W-1:0] rep_cnt [3];
  logic [REP_W-1:0] rep_nxt [3];
  logic [2:0]       rep_ev;
  logic [2:0]       rep_held;
  logic [2:0]       rep_rise;
  logic             suppress;
  logic [6:0]       ev;
  logic [6:0]       pend;
  logic [6:0]       pend_clr;
  logic [6:0]       pend_nxt;
  logic             ovf_hit;
  logic [2:0]       push_code;
  logic             push;
  logic             pop;
  logic             full;
  logic [2:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // Debounce: held flips once the raw bit has disagreed for DB_MAX polls.
  always_comb begin
    held_nxt = held;
    for (int i = 0; i < 8; i++) begin
      db_nxt[i] = '0;
      if (buttons[i] != held[i]) begin
        if (db_cnt[i] + 3'd1 == DB_MAX) held_nxt[i] = ~held[i];
        else                            db_nxt[i] = db_cnt[i] + 3'd1;
      end
    end
  end

  assign rise     = held_nxt & ~held;
  assign rep_held = {held_nxt[5], held_nxt[7], held_nxt[6]};
  assign rep_rise = {rise[5], rise[7], rise[6]};
  assign suppress = held_nxt[6] & held_nxt[7];

  // Auto-repeat: fire at DAS, then every ARR polls by wrapping TOP back to DAS.
  always_comb begin
    for (int j = 0; j < 3; j++) begin
      rep_nxt[j] = rep_cnt[j];
      rep_ev[j]  = 1'b0;
      if (!rep_held[j] || rep_rise[j]) begin
        rep_nxt[j] = '0;
      end else if (!(suppress && j < 2)) begin
        if (rep_cnt[j] + 1'b1 == REP_DAS) begin
          rep_ev[j]  = 1'b1;
          rep_nxt[j] = REP_DAS;
        end else if (rep_cnt[j] + 1'b1 >= REP_TOP) begin
          rep_ev[j]  = 1'b1;
          rep_nxt[j] = REP_DAS;
        end else begin
          rep_nxt[j] = rep_cnt[j] + 1'b1;
        end
      end
    end
  end

  // Event mask indexed by command code; Select (bit 2) is deliberately absent.
  always_comb begin
    ev = '0;
    if (buttons_valid) begin
      ev[0] = rise[6] | rep_ev[0];
      ev[1] = rise[7] | rep_ev[1];
      ev[2] = rise[5] | rep_ev[2];
      ev[3] = rise[4];
      ev[4] = rise[0];
      ev[5] = rise[1];
      ev[6] = rise[3];
    end
  end

  assign pop  = cmd_valid & cmd_ready;
  assign full = (count == FULL_CNT);
  assign push = (|pend) && (!full || pop);

  always_comb begin
    push_code = '0;
    for (int k = 6; k >= 0; k--) begin
      if (pend[k]) push_code = 3'(k);
    end
  end

  assign pend_clr = push ? (7'd1 << push_code) : 7'd0;
  assign pend_nxt = (pend & ~pend_clr) | ev;
  // A bit being drained this cycle is not lost, so only surviving bits count.
  assign ovf_hit  = |(ev & pend & ~pend_clr);

  always_ff @(posedge clk) begin
    if (!reset) begin
      held     <= '0;
      pend     <= '0;
      overflow <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      for (int i = 0; i < 8; i++) db_cnt[i] <= '0;
      for (int j = 0; j < 3; j++) rep_cnt[j] <= '0;
    end else begin
      if (buttons_valid) begin
        held <= held_nxt;
        for (int i = 0; i < 8; i++) db_cnt[i] <= db_nxt[i];
        for (int j = 0; j < 3; j++) rep_cnt[j] <= rep_nxt[j];
      end
      pend <= pend_nxt;
      if (ovf_hit) overflow <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_code;
  end

  assign cmd_valid = (count != '0);
  assign cmd       = cmd_valid ? mem[rd_ptr] : 3'd0;

endmodule

// File: tb/tb_button_event_gen.sv
module tb_button_event_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] buttons = '0;
  logic       buttons_valid = 1'b0;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic       cmd_ready = 1'b1;
  logic [7:0] held;
  logic       overflow;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int vld_cnt = 0;
  int got[$];
  int at[$];
  int n, dummy;
  int sc[0:20];
  int ek[5] = '{0, 10, 13, 16, 19};

  button_event_gen dut (
    .clk(clk), .reset(reset), .buttons(buttons), .buttons_valid(buttons_valid),
    .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .held(held), .overflow(overflow)
  );

  always #12.5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cmd_valid === 1'b1) vld_cnt++;
    if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
      got.push_back(int'(cmd));
      at.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic poll(input logic [7:0] b, output int sn);
    @(posedge clk); #1;
    buttons = b; buttons_valid = 1'b1; sn = cyc;
    @(posedge clk); #1;
    buttons_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    got.delete(); at.delete(); vld_cnt = 0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd", cmd, 0);
    chk("rst_vld", cmd_valid, 0);
    chk("rst_held", held, 0);
    chk("rst_ovf", overflow, 0);
    reset = 1'b1;
    clear_log();

    // Test 1: Left press after two strobes, latency 2 cycles
    poll(8'h40, dummy);
    chk("t1_held_mid", held, 0);
    poll(8'h40, n);
    chk("t1_cnt", got.size(), 1);
    chk("t1_cmd", got[0], 0);
    chk("t1_lat", at[0], n + 2);
    chk("t1_vld_cycles", vld_cnt, 1);
    chk("t1_held", held, 8'h40);
    poll(8'h00, dummy);
    poll(8'h00, dummy);
    chk("t1_rel_cnt", got.size(), 1);
    chk("t1_rel_held", held, 0);

    // Test 2: single-poll glitch on A is filtered
    clear_log();
    poll(8'h01, dummy);
    poll(8'h00, dummy);
    poll(8'h00, dummy);
    chk("t2_cnt", got.size(), 0);
    chk("t2_held", held, 0);

    // Test 3: Right held, DAS=10 then ARR=3
    clear_log();
    poll(8'h80, dummy);
    poll(8'h80, sc[0]);
    for (int k = 1; k <= 20; k++) poll(8'h80, sc[k]);
    chk("t3_cnt", got.size(), 5);
    for (int j = 0; j < 5; j++) begin
      chk("t3_cmd", got[j], 1);
      chk("t3_time", at[j], sc[ek[j]] + 2);
    end
    poll(8'h00, dummy);
    poll(8'h00, dummy);
    poll(8'h00, dummy);
    chk("t3_rel_cnt", got.size(), 5);
    chk("t3_rel_held", held, 0);

    // Test 4: four simultaneous presses fill the FIFO, then drain in order
    clear_log();
    cmd_ready = 1'b0;
    poll(8'h1B, dummy);
    poll(8'h1B, dummy);
    chk("t4_held", held, 8'h1B);
    chk("t4_vld", cmd_valid, 1);
    chk("t4_head", cmd, 3);
    repeat (5) @(posedge clk);
    #1;
    chk("t4_head_hold", cmd, 3);
    cmd_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("t4_cnt", got.size(), 4);
    for (int j = 0; j < 4; j++) chk("t4_order", got[j], j + 3);
    chk("t4_ovf", overflow, 0);
    chk("t4_empty", cmd_valid, 0);
    chk("t4_empty_cmd", cmd, 0);
    poll(8'h00, dummy);
    poll(8'h00, dummy);

    // Test 5: Left+Right together suppress repeats; Right release resumes Left
    clear_log();
    poll(8'hC0, dummy);
    poll(8'hC0, dummy);
    for (int k = 0; k < 13; k++) poll(8'hC0, dummy);
    chk("t5_cnt", got.size(), 2);
    chk("t5_first", got[0], 0);
    chk("t5_second", got[1], 1);
    poll(8'h40, dummy);
    poll(8'h40, dummy);
    chk("t5_held", held, 8'h40);
    for (int k = 0; k < 8; k++) poll(8'h40, dummy);
    chk("t5_no_rep_yet", got.size(), 2);
    poll(8'h40, dummy);
    chk("t5_rep_cnt", got.size(), 3);
    chk("t5_rep_cmd", got[2], 0);
    poll(8'h00, dummy);
    poll(8'h00, dummy);
    chk("t5_end_cnt", got.size(), 3);

    // Test 6: overflow on a re-fired pending event, then reset clears all
    clear_log();
    cmd_ready = 1'b0;
    poll(8'h1B, dummy);
    poll(8'h1B, dummy);
    poll(8'h1A, dummy);
    poll(8'h1A, dummy);
    poll(8'h1B, dummy);
    poll(8'h1B, dummy);
    chk("t6_ovf_pre", overflow, 0);
    poll(8'h1A, dummy);
    poll(8'h1A, dummy);
    poll(8'h1B, dummy);
    poll(8'h1B, dummy);
    chk("t6_ovf", overflow, 1);
    poll(8'h1B, dummy);
    chk("t6_ovf_sticky", overflow, 1);
    chk("t6_head", cmd, 3);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    chk("t6_rst_vld", cmd_valid, 0);
    chk("t6_rst_held", held, 0);
    chk("t6_rst_ovf", overflow, 0);
    chk("t6_rst_cmd", cmd, 0);
    cmd_ready = 1'b1;
    clear_log();
    repeat (10) @(posedge clk);
    #1;
    chk("t6_discard", got.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
